// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates cpu and debug ports onto one single-port SRAM
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_*/dbg_* req,we,be,addr,wdata  requester inputs (req held until granted)
//   cpu_gnt/dbg_gnt                combinational grant, at most one per cycle
//   cpu_rvalid/rdata, dbg_rvalid/rdata  read return, one cycle after a granted read
//   dbg_lock, dbg_owns             debug exclusive-ownership request / status
//   cpu_stall                      cpu_req & ~cpu_gnt
//   mem_en,we,be,addr,wdata,rdata  SRAM port, rdata valid one cycle after a read
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              dbg_owns,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {NORMAL, DBG_OWN} state_t;
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wait;
  logic              r_cpu_pend, r_dbg_pend;
  logic              w_dbg_win;
  always_ff @(posedge clk)
    r_state <= rst ? NORMAL : w_state_nxt;
  always_comb
    w_state_nxt = dbg_lock ? DBG_OWN : NORMAL;
  // Grants are masked by rst so nothing reaches the SRAM or the pending tags during reset.
  always_comb begin
    w_dbg_win  = dbg_req & (r_wait == WMAX);
    cpu_gnt    = ~rst & (r_state == NORMAL) & cpu_req & ~w_dbg_win;
    dbg_gnt    = ~rst & dbg_req & ((r_state == DBG_OWN) | w_dbg_win | ~cpu_req);
    dbg_owns   = ~rst & (r_state == DBG_OWN);
    cpu_stall  = ~rst & cpu_req & ~cpu_gnt;
    mem_en     = cpu_gnt | dbg_gnt;
    mem_we     = cpu_gnt ? cpu_we    : dbg_gnt & dbg_we;
    mem_be     = cpu_gnt ? cpu_be    : dbg_gnt ? dbg_be    : '0;
    mem_addr   = cpu_gnt ? cpu_addr  : dbg_gnt ? dbg_addr  : '0;
    mem_wdata  = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
    cpu_rvalid = ~rst & r_cpu_pend;
    dbg_rvalid = ~rst & r_dbg_pend;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk)
    if (rst | ~dbg_req | dbg_gnt)
      r_wait <= '0;
    else if (r_wait != WMAX)
      r_wait <= r_wait + 4'd1;
  // Owner tags follow the grant, so returns route correctly across lock changes.
  always_ff @(posedge clk) begin
    r_cpu_pend <= cpu_gnt & ~cpu_we;
    r_dbg_pend <= dbg_gnt & ~dbg_we;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-enabled SRAM model
module tb_dmem_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [3:0]  cpu_be = 0, dbg_be = 0;
  logic [9:0]  cpu_addr = 0, dbg_addr = 0;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, dbg_owns;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] sram [0:1023];
  logic [31:0] ref_mem [0:1023];
  typedef struct {bit dbg; logic [31:0] data;} rd_t;
  rd_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock), .dbg_owns(dbg_owns),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_be);
      else mem_rdata <= sram[mem_addr];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_cpu(input logic req, input logic we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
  endtask
  task automatic set_dbg(input logic req, input logic we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd);
    dbg_req = req; dbg_we = we; dbg_be = be; dbg_addr = a; dbg_wdata = wd;
  endtask
  task automatic cyc(input string tag, input logic ecg, input logic edg, input logic eown);
    rd_t e;
    logic ecv, edv, we;
    logic [31:0] ecd, edd, wd;
    logic [9:0] a;
    logic [3:0] be;
    ecv = 0; edv = 0; ecd = 0; edd = 0;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!rst) begin
        if (e.dbg) begin edv = 1; edd = e.data; end
        else begin ecv = 1; ecd = e.data; end
      end
    end
    chk({tag, ".cpu_rvalid"}, cpu_rvalid, ecv);
    chk({tag, ".cpu_rdata"}, cpu_rdata, ecd);
    chk({tag, ".dbg_rvalid"}, dbg_rvalid, edv);
    chk({tag, ".dbg_rdata"}, dbg_rdata, edd);
    chk({tag, ".cpu_gnt"}, cpu_gnt, ecg);
    chk({tag, ".dbg_gnt"}, dbg_gnt, edg);
    chk({tag, ".one_gnt"}, cpu_gnt & dbg_gnt, 0);
    chk({tag, ".dbg_owns"}, dbg_owns, eown);
    chk({tag, ".cpu_stall"}, cpu_stall, !rst && cpu_req && !ecg);
    chk({tag, ".mem_en"}, mem_en, ecg | edg);
    if (ecg | edg) begin
      a  = ecg ? cpu_addr : dbg_addr;
      we = ecg ? cpu_we : dbg_we;
      be = ecg ? cpu_be : dbg_be;
      wd = ecg ? cpu_wdata : dbg_wdata;
      chk({tag, ".mem_addr"}, mem_addr, a);
      chk({tag, ".mem_we"}, mem_we, we);
      if (we) begin
        chk({tag, ".mem_be"}, mem_be, be);
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
        ref_mem[a] = merge(ref_mem[a], wd, be);
      end else q.push_back('{edg, ref_mem[a]});
    end else begin
      chk({tag, ".mem_we"}, mem_we, 0);
      chk({tag, ".mem_be"}, mem_be, 0);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    logic [9:0]  pa [5];
    logic [31:0] pd [5];
    pa = '{10'd5, 10'd8, 10'd1, 10'd2, 10'd0};
    pd = '{32'hDEADBEEF, 32'h11223344, 32'h11111111, 32'h22222222, 32'h0BADF00D};
    @(posedge clk); #1;
    set_cpu(1, 0, 4'h0, 10'd5, 0);
    cyc("rst0", 0, 0, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    dbg_lock = 1;
    cyc("rst1", 0, 0, 0);
    dbg_lock = 0;
    rst = 0;
    cyc("idle", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_cpu(1, 1, 4'hF, pa[i], pd[i]);
      cyc($sformatf("pre%0d", i), 1, 0, 0);
    end
    set_cpu(1, 0, 4'h0, 10'd5, 0);
    cyc("cpu_rd5", 1, 0, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    cyc("cpu_rd5_rv", 0, 0, 0);
    set_cpu(1, 0, 4'h0, 10'd1, 0);
    set_dbg(1, 0, 4'h0, 10'd2, 0);
    for (int k = 0; k < 10; k++) cyc($sformatf("prio%0d", k), k % 5 != 4, k % 5 == 4, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    set_dbg(0, 0, 4'h0, 0, 0);
    cyc("prio_drain", 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      set_cpu(k % 2 == 0, 0, 4'h0, 10'd1, 0);
      set_dbg(k % 2 == 1, 0, 4'h0, 10'd2, 0);
      cyc($sformatf("alt%0d", k), k % 2 == 0, k % 2 == 1, 0);
    end
    set_cpu(0, 0, 4'h0, 0, 0);
    set_dbg(0, 0, 4'h0, 0, 0);
    cyc("alt_drain", 0, 0, 0);
    set_dbg(1, 1, 4'b0011, 10'd8, 32'hAABBCCDD);
    cyc("be_wr", 0, 1, 0);
    set_dbg(1, 0, 4'h0, 10'd8, 0);
    cyc("be_rd", 0, 1, 0);
    set_dbg(0, 0, 4'h0, 0, 0);
    cyc("be_rv", 0, 0, 0);
    set_cpu(1, 0, 4'h0, 10'd0, 0);
    dbg_lock = 1;
    cyc("lock_edge", 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      set_dbg(1, 1, 4'hF, 10'(k), 32'h0000_0013);
      cyc($sformatf("lock_wr%0d", k), 0, 1, 1);
    end
    set_dbg(0, 0, 4'h0, 0, 0);
    dbg_lock = 0;
    cyc("unlock", 0, 0, 1);
    cyc("after_unlock", 1, 0, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    cyc("after_unlock_rv", 0, 0, 0);
    set_cpu(1, 0, 4'h0, 10'd5, 0);
    cyc("pre_rst_rd", 1, 0, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    rst = 1;
    cyc("in_rst0", 0, 0, 0);
    cyc("in_rst1", 0, 0, 0);
    rst = 0;
    cyc("post_rst0", 0, 0, 0);
    cyc("post_rst1", 0, 0, 0);
    set_cpu(1, 0, 4'h0, 10'd5, 0);
    cyc("post_rst_rd", 1, 0, 0);
    set_cpu(0, 0, 4'h0, 0, 0);
    cyc("post_rst_rv", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
